// File: rtl/breakout_pkg.sv
// Purpose: shared state encodings, geometry constants and helpers for the breakout game sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_FRAME = 3'd0,
    ST_RESTORE    = 3'd1,
    ST_SERVE      = 3'd2,
    ST_PLAY       = 3'd3,
    ST_LOST       = 3'd4,
    ST_OVER       = 3'd5,
    ST_WIN        = 3'd6
  } state_e;

  // Sticky per-frame collision flags, packed into one bus between collide and control.
  typedef struct packed {
    logic t;
    logic b;
    logic l;
    logic r;
    logic pad;
    logic lost;
  } hits_t;

  localparam int H_DRAW     = 640;
  localparam int V_DRAW     = 480;
  localparam int BALL_SIZE  = 16;
  localparam int PADDLE_W   = 64;
  localparam int PADDLE_TOP = V_DRAW - 46;
  // Ball served centred on the paddle.
  localparam int SERVE_XOFF = PADDLE_W / 2 - BALL_SIZE / 2;
  localparam int BORDER     = 4;
  // Paddle sits a fixed distance above the bottom of the visible area.
  localparam int PADDLE_GAP = V_DRAW - PADDLE_TOP;

  function automatic logic [10:0] clamp11(input logic [10:0] v,
                                          input logic [10:0] lo,
                                          input logic [10:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/breakout_collide.sv
// Purpose: align pixel counters with playfield strobes and collect sticky ball collision flags.
// Latency: counters delayed 1 clk; flags visible 1 clk after the strobe; brick_hit_now combinational.
// Backpressure: none; strobes are consumed every clk.
// Ports: clk/rst_n (sync, active low); active = game in play; clr = drop flags at frame update;
//        counter_x/y raw pixel position; ball_x/y ball top-left; dy_down ball moving down;
//        draw_* playfield strobes; hits = flag bus (hits_t layout); brick_hit_now = erase brick now.
module breakout_collide
  import breakout_pkg::*;
#(
  parameter int vDrawArea = V_DRAW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       clr,
  input  logic [9:0] counter_x,
  input  logic [8:0] counter_y,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic       dy_down,
  input  logic       draw_ball,
  input  logic       draw_border,
  input  logic       draw_paddle,
  input  logic       draw_brick,
  output logic [5:0] hits,
  output logic       brick_hit_now
);

  localparam logic [8:0] LOST_Y = 9'(vDrawArea - BORDER);

  logic [9:0] cx_q, cx_d;
  logic [8:0] cy_q, cy_d;
  hits_t      hits_q, hits_d;
  logic [3:0] ox, oy;

  always_comb begin
    cx_d   = counter_x;
    cy_d   = counter_y;
    // Offset of the strobed pixel inside the 16x16 ball sprite.
    ox     = 4'(cx_q - ball_x);
    oy     = 4'(cy_q - ball_y);
    hits_d = hits_q;
    if (clr || !active) begin
      hits_d = '0;
    end else begin
      if (draw_ball && (draw_border || draw_brick)) begin
        if (oy == 4'd0)  hits_d.t = 1'b1;
        if (oy == 4'd15) hits_d.b = 1'b1;
        if (ox == 4'd0)  hits_d.l = 1'b1;
        if (ox == 4'd15) hits_d.r = 1'b1;
      end
      // Paddle only bounces a falling ball, so a ball rising through it is not re-flipped.
      if (draw_ball && draw_paddle && dy_down) hits_d.pad = 1'b1;
      if (draw_ball && draw_border && (cy_q >= LOST_Y)) hits_d.lost = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx_q   <= '0;
      cy_q   <= '0;
      hits_q <= '0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      hits_q <= hits_d;
    end
  end

  assign hits          = hits_q;
  assign brick_hit_now = active & draw_ball & draw_brick;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Purpose: breakout game sequencer - ball motion, wall restore, lives, score and brick count.
// Latency: state/ball update on the frame_tick clk; BrickHit_now combinational from the strobes.
// Backpressure: none; frame_tick, strobes and BrickHit_acq are consumed every clk.
// Ports: clk/rst_n (sync, active low); frame_tick start of frame; CounterX/Y pixel counters;
//        PaddleX paddle left edge; serve_btn launch/restart; Draw* playfield strobes (1 clk late);
//        BrickHit_acq brick removed; ballX/Y ball position; RestoreBrickwall; BrickHit_now;
//        score, lives, bricks_left counters; game_state encoded FSM state.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int hDrawArea  = H_DRAW,
  parameter int vDrawArea  = V_DRAW,
  parameter int BALL_SPEED = 2,
  parameter int LIVES      = 3,
  parameter int BRICKS     = 133
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic [9:0] PaddleX,
  input  logic       serve_btn,
  input  logic       DrawBall,
  input  logic       DrawBorder,
  input  logic       DrawPaddle,
  input  logic       DrawBrick,
  input  logic       BrickHit_acq,
  output logic [9:0] ballX,
  output logic [8:0] ballY,
  output logic       RestoreBrickwall,
  output logic       BrickHit_now,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [7:0] bricks_left,
  output logic [2:0] game_state
);

  localparam logic [10:0] B_MIN       = 11'(BORDER);
  localparam logic [10:0] X_MAX       = 11'(hDrawArea - BALL_SIZE - BORDER);
  localparam logic [10:0] Y_MAX       = 11'(vDrawArea - BALL_SIZE - BORDER);
  localparam logic [10:0] SPEED       = 11'(BALL_SPEED);
  localparam logic [9:0]  SERVE_X_OFS = 10'(SERVE_XOFF);
  localparam logic [9:0]  RST_X       = 10'(hDrawArea / 2 - BALL_SIZE / 2);
  localparam logic [8:0]  SERVE_Y     = 9'(vDrawArea - PADDLE_GAP - BALL_SIZE);
  localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);
  localparam logic [7:0]  BRICKS_INIT = 8'(BRICKS);

  state_e     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [8:0] ball_y_q, ball_y_d;
  logic       dx_q, dx_d;          // 1 = moving right
  logic       dy_q, dy_d;          // 1 = moving down
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] bricks_q, bricks_d;

  logic [5:0] hits_flat;
  hits_t      hits;
  logic       play;

  logic       dx_new, dy_new, bounce_up;
  logic [10:0] x_ext, y_ext, x_step, y_step, x_mv, y_mv;
  logic [7:0] bricks_acc, score_acc;

  assign play = (state_q == ST_PLAY);
  assign hits = hits_t'(hits_flat);

  breakout_collide #(.vDrawArea(vDrawArea)) u_collide (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (play),
    .clr           (frame_tick),
    .counter_x     (CounterX),
    .counter_y     (CounterY),
    .ball_x        (ball_x_q),
    .ball_y        (ball_y_q),
    .dy_down       (dy_q),
    .draw_ball     (DrawBall),
    .draw_border   (DrawBorder),
    .draw_paddle   (DrawPaddle),
    .draw_brick    (DrawBrick),
    .hits          (hits_flat),
    .brick_hit_now (BrickHit_now)
  );

  // Next direction and position if the frame ends in normal play.
  always_comb begin
    dx_new = dx_q;
    if (hits.l && !hits.r)      dx_new = 1'b1;
    else if (hits.r && !hits.l) dx_new = 1'b0;

    bounce_up = hits.b | hits.pad;
    dy_new    = dy_q;
    // Squeezed between a top and a bottom contact: just reverse.
    if (hits.t && bounce_up) dy_new = ~dy_q;
    else if (hits.t)         dy_new = 1'b1;
    else if (bounce_up)      dy_new = 1'b0;

    x_ext  = {1'b0, ball_x_q};
    y_ext  = {2'b0, ball_y_q};
    x_step = dx_new ? (x_ext + SPEED) : ((x_ext < B_MIN + SPEED) ? B_MIN : (x_ext - SPEED));
    y_step = dy_new ? (y_ext + SPEED) : ((y_ext < B_MIN + SPEED) ? B_MIN : (y_ext - SPEED));
    x_mv   = clamp11(x_step, B_MIN, X_MAX);
    y_mv   = clamp11(y_step, B_MIN, Y_MAX);
  end

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    lives_d  = lives_q;

    // Acks in the frame_tick clk are folded in before the win check.
    bricks_acc = bricks_q;
    score_acc  = score_q;
    if (play && BrickHit_acq) begin
      if (bricks_q != 8'd0)  bricks_acc = bricks_q - 8'd1;
      if (score_q != 8'hFF) score_acc  = score_q + 8'd1;
    end
    bricks_d = bricks_acc;
    score_d  = score_acc;

    case (state_q)
      ST_WAIT_FRAME: if (frame_tick) state_d = ST_RESTORE;
      ST_RESTORE: begin
        if (frame_tick) begin
          state_d  = ST_SERVE;
          bricks_d = BRICKS_INIT;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          ball_x_d = PaddleX + SERVE_X_OFS;
          ball_y_d = SERVE_Y;
          dx_d     = 1'b1;
          dy_d     = 1'b0;
          if (serve_btn) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (bricks_acc == 8'd0) begin
            state_d = ST_WIN;
          end else if (hits.lost) begin
            state_d = ST_LOST;
          end else begin
            dx_d     = dx_new;
            dy_d     = dy_new;
            ball_x_d = 10'(x_mv);
            ball_y_d = 9'(y_mv);
          end
        end
      end
      // One-clk bookkeeping state between a lost ball and the next serve.
      ST_LOST: begin
        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
        state_d = (lives_q <= 2'd1) ? ST_OVER : ST_SERVE;
      end
      ST_OVER, ST_WIN: begin
        if (frame_tick && serve_btn) begin
          state_d = ST_RESTORE;
          score_d = 8'd0;
          lives_d = LIVES_INIT;
        end
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT_FRAME;
      ball_x_q <= RST_X;
      ball_y_q <= SERVE_Y;
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      score_q  <= 8'd0;
      lives_q  <= LIVES_INIT;
      bricks_q <= BRICKS_INIT;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      bricks_q <= bricks_d;
    end
  end

  // Wall is rebuilt for exactly the frame spent in RESTORE.
  assign RestoreBrickwall = (state_q == ST_RESTORE);
  assign ballX            = ball_x_q;
  assign ballY            = ball_y_q;
  assign score            = score_q;
  assign lives            = lives_q;
  assign bricks_left      = bricks_q;
  assign game_state       = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
module tb_breakout_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic [9:0] PaddleX;
  logic       serve_btn;
  logic       DrawBall, DrawBorder, DrawPaddle, DrawBrick;
  logic       BrickHit_acq;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic       RestoreBrickwall;
  logic       BrickHit_now;
  logic [7:0] score;
  logic [1:0] lives;
  logic [7:0] bricks_left;
  logic [2:0] game_state;

  int tests = 0;
  int fails = 0;

  breakout_game_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .CounterX         (CounterX),
    .CounterY         (CounterY),
    .PaddleX          (PaddleX),
    .serve_btn        (serve_btn),
    .DrawBall         (DrawBall),
    .DrawBorder       (DrawBorder),
    .DrawPaddle       (DrawPaddle),
    .DrawBrick        (DrawBrick),
    .BrickHit_acq     (BrickHit_acq),
    .ballX            (ballX),
    .ballY            (ballY),
    .RestoreBrickwall (RestoreBrickwall),
    .BrickHit_now     (BrickHit_now),
    .score            (score),
    .lives            (lives),
    .bricks_left      (bricks_left),
    .game_state       (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_tick = 1'b1;
    tick_edge();
    frame_tick = 1'b0;
  endtask

  // Present a pixel on the counters, then its strobes one clk later.
  task automatic pixel(input int x, input int y, input logic b, input logic bo,
                       input logic pa, input logic br);
    CounterX = 10'(x);
    CounterY = 9'(y);
    tick_edge();
    DrawBall = b; DrawBorder = bo; DrawPaddle = pa; DrawBrick = br;
    tick_edge();
    DrawBall = 1'b0; DrawBorder = 1'b0; DrawPaddle = 1'b0; DrawBrick = 1'b0;
    CounterX = '0; CounterY = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick_edge();
    tests++; if (game_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    tests++; if ({ballX, ballY} !== {10'd312, 9'd418}) begin fails++; $display("FAIL reset_ball: got %0d,%0d expected 312,418", ballX, ballY); end
    tests++; if ({score, lives, bricks_left} !== {8'd0, 2'd3, 8'd133}) begin fails++; $display("FAIL reset_counters: got score %0d lives %0d bricks %0d expected 0 3 133", score, lives, bricks_left); end
    tests++; if ({RestoreBrickwall, BrickHit_now} !== 2'b00) begin fails++; $display("FAIL reset_outputs: got %b expected 00", {RestoreBrickwall, BrickHit_now}); end
    rst_n = 1'b1;
    repeat (4) tick_edge();
    tests++; if (game_state !== 3'd0) begin fails++; $display("FAIL wait_frame_hold: got %0d expected 0", game_state); end
  endtask

  task automatic test_restore();
    int cnt;
    cnt = 0;
    pulse();
    tests++; if (game_state !== 3'd1) begin fails++; $display("FAIL restore_enter: got %0d expected 1", game_state); end
    for (int i = 0; i < 19; i++) begin
      if (RestoreBrickwall) cnt++;
      tick_edge();
    end
    frame_tick = 1'b1;
    if (RestoreBrickwall) cnt++;
    tick_edge();
    frame_tick = 1'b0;
    tests++; if (cnt !== 20) begin fails++; $display("FAIL restore_len: got %0d clks expected 20", cnt); end
    tests++; if (RestoreBrickwall !== 1'b0) begin fails++; $display("FAIL restore_drop: got %b expected 0", RestoreBrickwall); end
    tests++; if ({game_state, bricks_left} !== {3'd2, 8'd133}) begin fails++; $display("FAIL restore_to_serve: got state %0d bricks %0d expected 2 133", game_state, bricks_left); end
  endtask

  task automatic test_serve_launch();
    PaddleX = 10'd100;
    tick_edge();
    pulse();
    tests++; if ({game_state, ballX, ballY} !== {3'd2, 10'd124, 9'd418}) begin fails++; $display("FAIL serve_place: got state %0d ball %0d,%0d expected 2 124,418", game_state, ballX, ballY); end
    repeat (3) tick_edge();
    serve_btn = 1'b1;
    pulse();
    serve_btn = 1'b0;
    tests++; if ({game_state, ballX, ballY} !== {3'd3, 10'd124, 9'd418}) begin fails++; $display("FAIL serve_launch: got state %0d ball %0d,%0d expected 3 124,418", game_state, ballX, ballY); end
    repeat (3) tick_edge();
    pulse();
    tests++; if ({ballX, ballY} !== {10'd126, 9'd416}) begin fails++; $display("FAIL first_move: got %0d,%0d expected 126,416", ballX, ballY); end
  endtask

  task automatic test_brick_hit();
    CounterX = 10'd131; CounterY = 9'd421;
    tick_edge();
    DrawBrick = 1'b1;
    #1;
    tests++; if (BrickHit_now !== 1'b0) begin fails++; $display("FAIL brick_no_ball: got %b expected 0", BrickHit_now); end
    DrawBall = 1'b1;
    #1;
    tests++; if (BrickHit_now !== 1'b1) begin fails++; $display("FAIL brick_hit_now: got %b expected 1", BrickHit_now); end
    tick_edge();
    DrawBall = 1'b0; DrawBrick = 1'b0; BrickHit_acq = 1'b1;
    #1;
    tests++; if (BrickHit_now !== 1'b0) begin fails++; $display("FAIL brick_hit_pulse: got %b expected 0", BrickHit_now); end
    tick_edge();
    BrickHit_acq = 1'b0;
    tests++; if ({bricks_left, score} !== {8'd132, 8'd1}) begin fails++; $display("FAIL brick_count: got bricks %0d score %0d expected 132 1", bricks_left, score); end
    pulse();
    tests++; if ({ballX, ballY} !== {10'd128, 9'd414}) begin fails++; $display("FAIL move_after_brick: got %0d,%0d expected 128,414", ballX, ballY); end
  endtask

  task automatic test_wall_bounce();
    repeat (205) begin pulse(); tick_edge(); end
    tests++; if ({ballX, ballY} !== {10'd538, 9'd4}) begin fails++; $display("FAIL climb_top: got %0d,%0d expected 538,4", ballX, ballY); end
    pulse(); tick_edge();
    tests++; if ({ballX, ballY} !== {10'd540, 9'd4}) begin fails++; $display("FAIL clamp_top: got %0d,%0d expected 540,4", ballX, ballY); end
    pixel(555, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse();
    tests++; if ({ballX, ballY} !== {10'd538, 9'd6}) begin fails++; $display("FAIL corner_tr: got %0d,%0d expected 538,6", ballX, ballY); end
    tick_edge();
    pulse();
    tests++; if ({ballX, ballY} !== {10'd536, 9'd8}) begin fails++; $display("FAIL after_corner: got %0d,%0d expected 536,8", ballX, ballY); end
    pixel(539, 11, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse();
    tests++; if ({ballX, ballY} !== {10'd534, 9'd6}) begin fails++; $display("FAIL paddle_bounce: got %0d,%0d expected 534,6", ballX, ballY); end
    pixel(539, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    pixel(539, 21, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse();
    tests++; if ({ballX, ballY} !== {10'd532, 9'd8}) begin fails++; $display("FAIL top_bottom_toggle: got %0d,%0d expected 532,8", ballX, ballY); end
    pixel(532, 13, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse();
    tests++; if ({ballX, ballY} !== {10'd534, 9'd10}) begin fails++; $display("FAIL left_bounce: got %0d,%0d expected 534,10", ballX, ballY); end
  endtask

  task automatic test_lost_and_over();
    pixel(539, 476, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse();
    tests++; if ({game_state, lives} !== {3'd4, 2'd3}) begin fails++; $display("FAIL lost_enter: got state %0d lives %0d expected 4 3", game_state, lives); end
    tick_edge();
    tests++; if ({game_state, lives} !== {3'd2, 2'd2}) begin fails++; $display("FAIL lost_to_serve: got state %0d lives %0d expected 2 2", game_state, lives); end
    serve_btn = 1'b1; pulse(); serve_btn = 1'b0;
    pixel(129, 476, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(); tick_edge();
    tests++; if ({game_state, lives} !== {3'd2, 2'd1}) begin fails++; $display("FAIL second_loss: got state %0d lives %0d expected 2 1", game_state, lives); end
    serve_btn = 1'b1; pulse(); serve_btn = 1'b0;
    pixel(129, 476, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse();
    tests++; if (game_state !== 3'd4) begin fails++; $display("FAIL last_lost: got %0d expected 4", game_state); end
    tick_edge();
    tests++; if ({game_state, lives} !== {3'd5, 2'd0}) begin fails++; $display("FAIL game_over: got state %0d lives %0d expected 5 0", game_state, lives); end
    BrickHit_acq = 1'b1; DrawBall = 1'b1; DrawBrick = 1'b1;
    #1;
    tests++; if (BrickHit_now !== 1'b0) begin fails++; $display("FAIL over_brick_now: got %b expected 0", BrickHit_now); end
    tick_edge();
    BrickHit_acq = 1'b0; DrawBall = 1'b0; DrawBrick = 1'b0;
    tests++; if ({bricks_left, score} !== {8'd132, 8'd1}) begin fails++; $display("FAIL over_acq_ignored: got bricks %0d score %0d expected 132 1", bricks_left, score); end
    pulse();
    tests++; if ({game_state, ballX, ballY} !== {3'd5, 10'd124, 9'd418}) begin fails++; $display("FAIL over_frozen: got state %0d ball %0d,%0d expected 5 124,418", game_state, ballX, ballY); end
    serve_btn = 1'b1; pulse(); serve_btn = 1'b0;
    tests++; if ({game_state, lives, score, RestoreBrickwall} !== {3'd1, 2'd3, 8'd0, 1'b1}) begin fails++; $display("FAIL restart: got state %0d lives %0d score %0d restore %b expected 1 3 0 1", game_state, lives, score, RestoreBrickwall); end
    repeat (5) tick_edge();
    pulse();
    tests++; if ({game_state, bricks_left} !== {3'd2, 8'd133}) begin fails++; $display("FAIL restart_serve: got state %0d bricks %0d expected 2 133", game_state, bricks_left); end
  endtask

  task automatic test_win_priority();
    serve_btn = 1'b1; pulse(); serve_btn = 1'b0;
    repeat (132) begin
      BrickHit_acq = 1'b1; tick_edge();
      BrickHit_acq = 1'b0; tick_edge();
    end
    tests++; if ({game_state, bricks_left, score} !== {3'd3, 8'd1, 8'd132}) begin fails++; $display("FAIL win_setup: got state %0d bricks %0d score %0d expected 3 1 132", game_state, bricks_left, score); end
    pixel(129, 476, 1'b1, 1'b1, 1'b0, 1'b0);
    BrickHit_acq = 1'b1; frame_tick = 1'b1;
    tick_edge();
    BrickHit_acq = 1'b0; frame_tick = 1'b0;
    tests++; if ({game_state, bricks_left, score, lives} !== {3'd6, 8'd0, 8'd133, 2'd3}) begin fails++; $display("FAIL win_priority: got state %0d bricks %0d score %0d lives %0d expected 6 0 133 3", game_state, bricks_left, score, lives); end
    tick_edge();
    pulse();
    tests++; if ({game_state, ballX, ballY} !== {3'd6, 10'd124, 9'd418}) begin fails++; $display("FAIL win_frozen: got state %0d ball %0d,%0d expected 6 124,418", game_state, ballX, ballY); end
  endtask

  task automatic test_reset_midframe();
    serve_btn = 1'b1; pulse(); serve_btn = 1'b0;
    repeat (2) tick_edge();
    rst_n = 1'b0;
    tick_edge();
    rst_n = 1'b1;
    tests++; if ({game_state, RestoreBrickwall} !== {3'd0, 1'b0}) begin fails++; $display("FAIL midframe_reset: got state %0d restore %b expected 0 0", game_state, RestoreBrickwall); end
    tests++; if ({bricks_left, score, ballX, ballY} !== {8'd133, 8'd0, 10'd312, 9'd418}) begin fails++; $display("FAIL midframe_values: got bricks %0d score %0d ball %0d,%0d expected 133 0 312,418", bricks_left, score, ballX, ballY); end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; CounterX = '0; CounterY = '0; PaddleX = '0;
    serve_btn = 1'b0; DrawBall = 1'b0; DrawBorder = 1'b0; DrawPaddle = 1'b0;
    DrawBrick = 1'b0; BrickHit_acq = 1'b0;
    test_reset();
    test_restore();
    test_serve_launch();
    test_brick_hit();
    test_wall_bounce();
    test_lost_and_over();
    test_win_priority();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
Game sequencer for breakout_playfield.
- Owns ball position and direction, and drives RestoreBrickwall and BrickHit_now.
- Classifies per-pixel collisions from the playfield draw strobes, updates ball motion once per frame, and tracks lives, score and bricks remaining.
- Sits between the VGA timing generator and breakout_playfield.

Parameters:
hDrawArea, 640, visible width in pixels
vDrawArea, 480, visible height in pixels
BALL_SPEED, 2, pixels moved per axis per frame (1..4)
LIVES, 3, lives at game start (1..3)
BRICKS, 133, brick count of a full wall (19 x 7)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
frame_tick  in  1  one-clk pulse at CounterX=0, CounterY=0 of each frame
CounterX  in  10  current pixel X
CounterY  in  9  current pixel Y
PaddleX  in  10  paddle left edge
serve_btn  in  1  level; launch ball or restart game
DrawBall, DrawBorder, DrawPaddle, DrawBrick  in  1 each  playfield strobes, one clk behind the counters
BrickHit_acq  in  1  playfield confirms a brick was removed
ballX  out  10  ball left edge
ballY  out  9  ball top edge
RestoreBrickwall  out  1  rebuild wall for one full frame
BrickHit_now  out  1  clear brick at the current pixel
score  out  8  bricks destroyed, saturates at 255
lives  out  2  lives remaining
bricks_left  out  8  bricks remaining
game_state  out  3  encoded FSM state

Behaviour:
Reset (rst_n low at a clk edge):
- State = WAIT_FRAME; ballX=312, ballY=418.
- dx=+1, dy=-1 (up).
- score=0, lives=LIVES, bricks_left=BRICKS.
- RestoreBrickwall=0, BrickHit_now=0; all collision flags cleared.
- Reset mid-frame aborts any restore or play immediately.

FSM:
- WAIT_FRAME -> RESTORE on frame_tick.
- RESTORE: RestoreBrickwall=1 from the clk after entry through the clk of the next frame_tick inclusive. Then -> SERVE with bricks_left=BRICKS.
- SERVE:
  - Every frame_tick: ballX=PaddleX+24, ballY=vDrawArea-62 (418), dx=+1, dy=-1.
  - serve_btn=1 sampled at frame_tick -> PLAY.
- PLAY: collision classification active; ball moves at every frame_tick.
- LOST (entered at frame_tick):
  - lives decremented.
  - If lives becomes 0 -> OVER, else -> SERVE.
- WIN: entered when bricks_left reaches 0.
- OVER / WIN: ball frozen. serve_btn=1 at frame_tick -> RESTORE, with score=0 and lives=LIVES.
- Encoding: WAIT_FRAME=0, RESTORE=1, SERVE=2, PLAY=3, LOST=4, OVER=5, WIN=6.

Collision classification (PLAY only):
- CounterX/Y are delayed one clk to align with the Draw strobes.
- ox = CounterX_d - ballX, oy = CounterY_d - ballY, each 4 bits.
- On DrawBall & (DrawBorder | DrawBrick):
  - oy==0 sets hitT; oy==15 sets hitB.
  - ox==0 sets hitL; ox==15 sets hitR.
  - Corner pixels set two flags.
- DrawBall & DrawPaddle & dy=down sets hitPad.
- DrawBall & DrawBorder with CounterY_d >= vDrawArea-4 sets lost.
- BrickHit_now = (state==PLAY) & DrawBall & DrawBrick, combinational, no extra latency.
- Flags are sticky until the frame_tick update, then cleared in the same clk.

Frame update at frame_tick in PLAY, in priority order:
1. bricks_left==0 -> WIN.
2. lost -> LOST.
3. Otherwise:
   - hitL & !hitR -> dx=+; hitR & !hitL -> dx=-.
   - hitT -> dy=+; hitB | hitPad -> dy=-.
   - If hitT and (hitB | hitPad) are both set, dy toggles.
   - Then ballX += dx*BALL_SPEED, ballY += dy*BALL_SPEED using the new directions.
   - Clamp to [4, hDrawArea-20] and [4, vDrawArea-20].

Brick accounting (PLAY only):
- Each BrickHit_acq pulse: bricks_left -= 1 (floor 0), score += 1 (saturating).
- An acq in the same clk as frame_tick is counted before the WIN check.
- BrickHit_acq outside PLAY is ignored.

Decomposition:
- Package breakout_pkg: state encodings, BALL_SIZE=16, PADDLE_W=64, PADDLE_TOP=vDrawArea-46, SERVE_XOFF=24, BORDER=4.
- Sub-module breakout_collide: counter delay, ox/oy compute, sticky hit flags with clear input, BrickHit_now generation.

Test Plan:
1. Reset, then 2 frame_ticks -> RestoreBrickwall high for exactly one frame (hDrawArea*vDrawArea visible clks plus blanking); state=SERVE, bricks_left=133.
2. SERVE, PaddleX=100 -> ballX=124, ballY=418 at frame_tick; serve_btn at frame_tick -> PLAY; next frame ballX=126, ballY=416.
3. Ball at ballY=4 moving up, DrawBorder overlapping oy=0 -> hitT; at next frame_tick dy=down and ballY=6.
4. DrawBall&DrawBrick for one pixel, BrickHit_acq one clk later -> BrickHit_now pulse 1 clk, bricks_left 133->132, score=1.
5. Bottom border hit with lives=1 -> lives=0, LOST then OVER; serve_btn -> RESTORE, lives=3, score=0.
6. bricks_left=1: acq and lost in the same frame -> WIN takes priority, lives unchanged.
